// File: rtl/ysyx_22040931_mem_arb.sv
// Shares one memory port between instruction fetch and the load/store path.
// One transaction in flight at a time: grant in IDLE, present in ISSUE, collect in WAIT.
module ysyx_22040931_mem_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [2:0]  IF_ROP     = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wr,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [2:0]        lsu_req_wop,
  input  logic [2:0]        lsu_req_rop,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [2:0]        mem_req_wop,
  output logic [2:0]        mem_req_rop,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_lsu_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        wop_q, rop_q;
  logic              if_resp_valid_q, lsu_resp_valid_q;
  logic [DATA_W-1:0] if_resp_data_q, lsu_resp_data_q;
  logic              grant_if, grant_lsu, starved, resp_fire;

  assign starved   = (starve_q == 4'(STARVE_MAX));
  assign resp_fire = (state_q == StWait) && mem_resp_valid;

  // Ready is the grant itself; held low while reset is asserted so every output reads 0.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (if_req_valid && (starved || !lsu_req_valid)) begin
        grant_if = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if || grant_lsu) state_d = StIssue;
        if (grant_if || !if_req_valid) begin
          starve_d = 4'd0;
        end else if (grant_lsu && !starved) begin
          starve_d = starve_q + 4'd1;
        end
      end
      StIssue: if (mem_req_ready) state_d = StWait;
      // A response coincident with acceptance is ignored: only WAIT listens.
      StWait:  if (mem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_lsu_q      <= 1'b0;
      wr_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wop_q            <= 3'd0;
      rop_q            <= 3'd0;
      if_resp_valid_q  <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      if_resp_data_q   <= '0;
      lsu_resp_data_q  <= '0;
    end else begin
      if (grant_if) begin
        owner_lsu_q <= 1'b0;
        wr_q        <= 1'b0;
        addr_q      <= if_req_addr;
        wdata_q     <= '0;
        wop_q       <= 3'd0;
        rop_q       <= IF_ROP;
      end else if (grant_lsu) begin
        owner_lsu_q <= 1'b1;
        wr_q        <= lsu_req_wr;
        addr_q      <= lsu_req_addr;
        wdata_q     <= lsu_req_wdata;
        wop_q       <= lsu_req_wop;
        rop_q       <= lsu_req_rop;
      end
      if_resp_valid_q  <= resp_fire && !owner_lsu_q;
      lsu_resp_valid_q <= resp_fire && owner_lsu_q;
      if (resp_fire && !owner_lsu_q) if_resp_data_q <= mem_resp_data;
      if (resp_fire && owner_lsu_q) lsu_resp_data_q <= mem_resp_data;
    end
  end

  assign if_req_ready   = grant_if;
  assign lsu_req_ready  = grant_lsu;
  assign if_resp_valid  = if_resp_valid_q;
  assign if_resp_data   = if_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign mem_req_valid  = (state_q == StIssue);
  assign mem_req_wr     = wr_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wop    = wop_q;
  assign mem_req_rop    = rop_q;
  assign busy           = (state_q != StIdle);

endmodule
